// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: FSM encoding,
// the halt opcode and the program store depth.
package instr_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_ISSUE_HI = 3'd2,
        ST_ISSUE_LO = 3'd3,
        ST_FIN      = 3'd4
    } state_t;

    localparam logic [3:0] OPR_HALT   = 4'b0000;
    localparam int         PROG_DEPTH = 8;

    function automatic logic is_halt(input logic [7:0] word);
        return word[7:4] == OPR_HALT;
    endfunction

endpackage

// File: rtl/instr_sequencer_btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, down-counter debounce
// and a one-cycle pulse on each accepted press.
module btn_debounce #(
    parameter int DB_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int CW = $clog2(DB_CYC + 1);
    localparam logic [CW-1:0] RELOAD = CW'(DB_CYC - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] cnt;

    // Level flips only when the synchronised input has disagreed with it
    // for DB_CYC consecutive samples; any agreement restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= 2'b00;
            level <= 1'b0;
            cnt   <= RELOAD;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            pulse <= 1'b0;
            if (sync[1] == level) begin
                cnt <= RELOAD;
            end else if (cnt == '0) begin
                level <= sync[1];
                cnt   <= RELOAD;
                pulse <= sync[1];
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Button-driven program store that replays up to eight instructions to the
// ALU stage as strobed {OPR, OPA} words.
//
//   state       | meaning
//   ST_IDLE     | accept LOAD / CLR / RUN pulses
//   ST_FETCH    | latch prog[pc] onto instr, stop on halt opcode
//   ST_ISSUE_HI | stb high for STB_CYC cycles
//   ST_ISSUE_LO | stb low for GAP_CYC cycles, then next word or finish
//   ST_FIN      | one-cycle done pulse, abort flag cleared
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int DB_CYC  = 16,
    parameter int STB_CYC = 4,
    parameter int GAP_CYC = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic       load_btn,
    input  logic       run_btn,
    input  logic       clr_btn,
    output logic [7:0] instr,
    output logic       stb,
    output logic [2:0] pc,
    output logic [3:0] count,
    output logic       busy,
    output logic       done
);

    localparam int TMAX = (STB_CYC > GAP_CYC) ? STB_CYC : GAP_CYC;
    localparam int TW   = $clog2(TMAX + 1);

    state_t        state, state_nx;
    logic [7:0]    prog [PROG_DEPTH];
    logic [2:0]    wp;
    logic          abort;
    logic [TW-1:0] tmr;
    logic          load_p, run_p, clr_p;
    logic          last_pc, tmr_tc, run_ok;

    btn_debounce #(.DB_CYC(DB_CYC)) u_db_load (.clk(clk), .rst_n(rst_n), .btn(load_btn), .pulse(load_p));
    btn_debounce #(.DB_CYC(DB_CYC)) u_db_run  (.clk(clk), .rst_n(rst_n), .btn(run_btn),  .pulse(run_p));
    btn_debounce #(.DB_CYC(DB_CYC)) u_db_clr  (.clk(clk), .rst_n(rst_n), .btn(clr_btn),  .pulse(clr_p));

    assign last_pc = ({1'b0, pc} == count - 4'd1);
    assign tmr_tc  = (tmr == '0);
    assign run_ok  = run_p && !load_p && !clr_p && (count != 4'd0);

    // Outputs decode straight from the state register so reset drops stb at once.
    assign stb  = (state == ST_ISSUE_HI);
    assign busy = (state != ST_IDLE);
    assign done = (state == ST_FIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (run_ok) state_nx = ST_FETCH;
            ST_FETCH:    state_nx = is_halt(prog[pc]) ? ST_FIN : ST_ISSUE_HI;
            ST_ISSUE_HI: if (tmr_tc) state_nx = ST_ISSUE_LO;
            ST_ISSUE_LO: if (tmr_tc) state_nx = (last_pc || abort) ? ST_FIN : ST_FETCH;
            ST_FIN:      state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PROG_DEPTH; i++) prog[i] <= 8'h00;
            wp    <= 3'd0;
            count <= 4'd0;
            pc    <= 3'd0;
            instr <= 8'h00;
            abort <= 1'b0;
            tmr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_p) begin
                        prog[wp] <= sw;
                        wp       <= wp + 3'd1;
                        if (count != 4'(PROG_DEPTH)) count <= count + 4'd1;
                    end else if (clr_p) begin
                        wp    <= 3'd0;
                        count <= 4'd0;
                    end else if (run_ok) begin
                        pc <= 3'd0;
                    end
                end
                ST_FETCH: begin
                    instr <= prog[pc];
                    tmr   <= TW'(STB_CYC - 1);
                end
                ST_ISSUE_HI: begin
                    if (tmr_tc) tmr <= TW'(GAP_CYC - 1);
                    else        tmr <= tmr - 1'b1;
                end
                ST_ISSUE_LO: begin
                    if (!tmr_tc)                  tmr <= tmr - 1'b1;
                    else if (!last_pc && !abort)  pc  <= pc + 3'd1;
                end
                default: ;
            endcase

            // Abort is sampled in any busy state; FIN clears it and wins.
            if (busy && clr_p) abort <= 1'b1;
            if (state == ST_FIN) abort <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a model of the program store feeds an
// expected-strobe queue that is popped as the DUT issues instructions.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    localparam int DB = 16;
    localparam int SC = 4;
    localparam int GC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       load_btn = 1'b0, run_btn = 1'b0, clr_btn = 1'b0;
    logic [7:0] instr;
    logic       stb;
    logic [2:0] pc;
    logic [3:0] count;
    logic       busy;
    logic       done;

    instr_sequencer #(.DB_CYC(DB), .STB_CYC(SC), .GAP_CYC(GC)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw),
        .load_btn(load_btn), .run_btn(run_btn), .clr_btn(clr_btn),
        .instr(instr), .stb(stb), .pc(pc), .count(count),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] word;
        logic [2:0] idx;
    } exp_t;

    int         errors = 0;
    int         checks = 0;
    exp_t       q[$];
    logic [7:0] m_prog [8];
    int         m_wp = 0;
    int         m_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int which);
        case (which)
            0: load_btn = 1'b1;
            1: clr_btn  = 1'b1;
            default: run_btn = 1'b1;
        endcase
        cycles(DB + 4);
        load_btn = 1'b0;
        clr_btn  = 1'b0;
        run_btn  = 1'b0;
        cycles(DB + 8);
    endtask

    task automatic load_word(input logic [7:0] w);
        sw = w;
        press(0);
        m_prog[m_wp] = w;
        m_wp = (m_wp + 1) % 8;
        if (m_count < 8) m_count++;
    endtask

    task automatic clear_prog();
        press(1);
        m_wp = 0;
        m_count = 0;
    endtask

    task automatic queue_run(input int max_stb);
        q.delete();
        for (int p = 0; p < m_count && q.size() < max_stb; p++) begin
            if (m_prog[p][7:4] == OPR_HALT) break;
            q.push_back({m_prog[p], 3'(p)});
        end
    endtask

    // Presses RUN (and optionally CLR at cycle clr_at) and checks every strobe.
    task automatic run_and_watch(input int clr_at, input int done_gap, input int exp_pc);
        int         strobes = 0, dones = 0, hi_len = 0;
        int         last_rise = 0, last_fall = 0;
        logic       prev = 1'b0;
        logic       finished = 1'b0;
        logic [7:0] held = 8'h00;
        exp_t       e;
        run_btn = 1'b1;
        for (int i = 1; i <= 400 && !finished; i++) begin
            @(negedge clk);
            if (i == DB + 4) run_btn = 1'b0;
            if (clr_at > 0 && i == clr_at) clr_btn = 1'b1;
            if (clr_at > 0 && i == clr_at + DB + 4) clr_btn = 1'b0;
            if (stb && !prev) begin
                strobes++;
                if (last_rise > 0) check("strobe_period", i - last_rise, SC + GC + 1);
                last_rise = i;
                check("strobe_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("strobe_instr", instr, e.word);
                    check("strobe_pc", pc, e.idx);
                end
                held = instr;
                hi_len = 1;
            end else if (stb) begin
                hi_len++;
                check("instr_stable", instr, held);
            end
            if (!stb && prev) begin
                check("stb_high_len", hi_len, SC);
                last_fall = i;
            end
            if (done) begin
                dones++;
                check("done_timing", i - last_fall, done_gap);
            end
            if (dones > 0 && !busy && !done) finished = 1'b1;
            prev = stb;
        end
        run_btn = 1'b0;
        clr_btn = 1'b0;
        check("done_count", dones, 1);
        check("queue_left", q.size(), 0);
        check("end_pc", pc, exp_pc);
        check("end_busy", busy, 0);
        cycles(DB + 8);
    endtask

    initial begin
        int   found;
        logic saw_busy;
        logic saw_stb;

        for (int k = 0; k < 8; k++) m_prog[k] = 8'h00;

        // reset state
        cycles(3);
        check("rst_stb", stb, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_instr", instr, 8'h00);
        check("rst_pc", pc, 0);
        check("rst_count", count, 0);
        rst_n = 1'b1;
        cycles(3);

        // three-word program
        load_word(8'h1A);
        load_word(8'h23);
        load_word(8'h49);
        check("count3", count, m_count);
        queue_run(8);
        run_and_watch(0, GC, 2);
        check("count3_after", count, 3);

        // halt in slot 1
        clear_prog();
        check("count_clr", count, 0);
        load_word(8'h15);
        load_word(8'h00);
        load_word(8'h16);
        queue_run(8);
        run_and_watch(0, GC + 1, 1);
        check("halt_instr", instr, 8'h00);

        // nine loads wrap the write pointer, count saturates
        clear_prog();
        for (int k = 0; k < 9; k++) load_word(8'h10 + 8'(k));
        check("count_sat", count, 8);
        queue_run(8);
        run_and_watch(0, GC, 7);

        // short glitch must not load; RUN with empty program is ignored
        clear_prog();
        load_btn = 1'b1;
        cycles(DB - 1);
        load_btn = 1'b0;
        cycles(DB + 8);
        check("glitch_count", count, m_count);
        saw_busy = 1'b0;
        run_btn = 1'b1;
        for (int i = 0; i < 3 * DB; i++) begin
            @(negedge clk);
            if (i == DB + 4) run_btn = 1'b0;
            saw_busy |= busy;
        end
        run_btn = 1'b0;
        check("empty_run_busy", saw_busy, 0);
        cycles(DB + 8);

        // CLR during the second strobe aborts after that strobe
        load_word(8'h31);
        load_word(8'h32);
        load_word(8'h33);
        load_word(8'h34);
        queue_run(2);
        run_and_watch(12, GC, 1);
        check("abort_count", count, 4);

        // reset in the second cycle of a strobe
        run_btn = 1'b1;
        found = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == DB + 4) run_btn = 1'b0;
            if (stb) begin
                found = 1;
                break;
            end
        end
        check("rst_strobe_seen", found, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_stb", stb, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_instr", instr, 8'h00);
        check("mid_rst_pc", pc, 0);
        check("mid_rst_count", count, 0);
        run_btn = 1'b0;
        m_wp = 0;
        m_count = 0;
        for (int k = 0; k < 8; k++) m_prog[k] = 8'h00;
        cycles(3);
        rst_n = 1'b1;
        saw_busy = 1'b0;
        saw_stb = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            saw_busy |= busy;
            saw_stb |= stb;
        end
        check("post_rst_busy", saw_busy, 0);
        check("post_rst_stb", saw_stb, 0);

        // store works again after reset
        load_word(8'h7E);
        check("post_rst_count", count, m_count);
        queue_run(8);
        run_and_watch(0, GC, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
